// File: rtl/switch_conditioner.sv
// Board switch front end: 2-flop synchronizer, per-bit debounce, rise pulses and sticky pending flags.
// Define SWITCH_COND_LOCKOUT_EN to suppress new rises for LOCKOUT_CYCLES after any reported rise.
module switch_conditioner #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LOCKOUT_CYCLES  = 125000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] SWITCHES,
  output logic [WIDTH-1:0] sw_level,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_pend,
  input  logic [WIDTH-1:0] pend_clr,
  output logic             lockout_active
);

  localparam int unsigned CNT_W = 24;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject parameter values the counters cannot represent
  if (DEBOUNCE_CYCLES == 0 || DEBOUNCE_CYCLES > 32'h00FF_FFFF ||
      LOCKOUT_CYCLES > 32'h07FF_FFFF) begin : g_param_check
    $error("switch_conditioner: DEBOUNCE_CYCLES or LOCKOUT_CYCLES out of range");
  end

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] level_d;
  logic [WIDTH-1:0] rise_c;

  // Two-flop synchronizer for the asynchronous switch inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= SWITCHES;
      s2 <= s1;
    end
  end

  // Per-channel debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing samples
  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    logic [CNT_W-1:0] cnt;
    logic             lvl;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (s2[i] == lvl) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        cnt <= '0;
        lvl <= s2[i];
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end

    assign sw_level[i] = lvl;
  end

  // Candidate rise pulses, masked while the lockout window is open
  always_comb begin
    rise_c = sw_level & ~level_d;
`ifdef SWITCH_COND_LOCKOUT_EN
    if (lockout_active) begin
      rise_c = '0;
    end
`endif
  end

  // Set wins over clear so a press coinciding with a clear is never lost
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_d <= '0;
      sw_rise <= '0;
      sw_pend <= '0;
    end else begin
      level_d <= sw_level;
      sw_rise <= rise_c;
      sw_pend <= (sw_pend & ~pend_clr) | sw_rise;
    end
  end

`ifdef SWITCH_COND_LOCKOUT_EN
  localparam int unsigned LOCK_W = 27;
  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES);

  logic [LOCK_W-1:0] lock_cnt;
  logic [LOCK_W-1:0] lock_cnt_nxt;

  // Any reported rise (re)opens the window; otherwise count down to zero
  always_comb begin
    lock_cnt_nxt = lock_cnt;
    if (sw_rise != '0) begin
      lock_cnt_nxt = LOCK_LOAD;
    end else if (lock_cnt != '0) begin
      lock_cnt_nxt = lock_cnt - LOCK_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_cnt       <= '0;
      lockout_active <= 1'b0;
    end else begin
      lock_cnt       <= lock_cnt_nxt;
      lockout_active <= (lock_cnt_nxt != '0);
    end
  end
`else
  assign lockout_active = 1'b0;
`endif

endmodule

// File: tb/tb_switch_conditioner.sv
// Scoreboard bench for switch_conditioner: reference model pushes expected outputs per edge,
// a separate monitor pops and compares them; directed scenarios plus randomized switch activity.
module tb_switch_conditioner;

  localparam int W = 4;
  localparam int D = 4;
  localparam int L = 8;

`ifdef SWITCH_COND_LOCKOUT_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] SWITCHES;
  logic [W-1:0] pend_clr;
  logic [W-1:0] sw_level;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_pend;
  logic         lockout_active;

  switch_conditioner #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(D),
    .LOCKOUT_CYCLES(L)
  ) dut (
    .clk(clk),
    .rst(rst),
    .SWITCHES(SWITCHES),
    .sw_level(sw_level),
    .sw_rise(sw_rise),
    .sw_pend(sw_pend),
    .pend_clr(pend_clr),
    .lockout_active(lockout_active)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] lvl;
    logic [W-1:0] rise;
    logic [W-1:0] pend;
    logic         lock;
  } snap_t;

  snap_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    edge_cnt = 0;
  int    rise_cnt [W] = '{default: 0};
  int    rise_edge[W] = '{default: -1};
  int    lock_hi = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: state after each clock edge, derived from the sampled-input history
  logic [W-1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_lvl_prev = '0, m_rise = '0, m_pend = '0;
  int           m_lock = 0;
  logic [W-1:0] hist[$];

  task automatic model_step(input logic [W-1:0] sw, input logic [W-1:0] clr, input logic r);
    logic [W-1:0] nl;
    logic [W-1:0] nr;
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_lvl_prev = '0; m_rise = '0; m_pend = '0;
      m_lock = 0;
      hist.delete();
      return;
    end
    hist.push_back(m_s2);
    if (hist.size() > D) void'(hist.pop_front());
    nl = m_lvl;
    if (hist.size() == D) begin
      for (int i = 0; i < W; i++) begin
        bit all_diff;
        all_diff = 1'b1;
        foreach (hist[k]) if (hist[k][i] == m_lvl[i]) all_diff = 1'b0;
        if (all_diff) nl[i] = ~m_lvl[i];
      end
    end
    nr = m_lvl & ~m_lvl_prev;
    if (LOCK_ON && m_lock != 0) nr = '0;
    m_pend     = (m_pend & ~clr) | m_rise;
    m_lock     = (m_rise != '0) ? L : ((m_lock > 0) ? m_lock - 1 : 0);
    m_s2       = m_s1;
    m_s1       = sw;
    m_lvl_prev = m_lvl;
    m_lvl      = nl;
    m_rise     = nr;
  endtask

  task automatic cyc(input logic [W-1:0] sw, input logic [W-1:0] clr, input logic r);
    snap_t s;
    @(negedge clk);
    rst      = r;
    SWITCHES = sw;
    pend_clr = clr;
    model_step(sw, clr, r);
    s.lvl  = m_lvl;
    s.rise = m_rise;
    s.pend = m_pend;
    s.lock = LOCK_ON && (m_lock != 0);
    exp_q.push_back(s);
  endtask

  task automatic async_reset(input logic [W-1:0] sw);
    cyc(sw, '0, 1'b1);
    #1;
    check("async_rst_level", 32'(sw_level), 0);
    check("async_rst_rise", 32'(sw_rise), 0);
    check("async_rst_pend", 32'(sw_pend), 0);
    check("async_rst_lock", 32'(lockout_active), 0);
  endtask

  // Monitor: compare DUT outputs against the scoreboard after every active edge
  initial begin
    snap_t e;
    forever begin
      @(posedge clk);
      edge_cnt++;
      #1;
      for (int i = 0; i < W; i++) begin
        if (sw_rise[i] === 1'b1) begin
          rise_cnt[i]++;
          rise_edge[i] = edge_cnt;
        end
      end
      if (lockout_active === 1'b1) lock_hi++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("level@%0d", edge_cnt), 32'(sw_level), 32'(e.lvl));
        check($sformatf("rise@%0d", edge_cnt), 32'(sw_rise), 32'(e.rise));
        check($sformatf("pend@%0d", edge_cnt), 32'(sw_pend), 32'(e.pend));
        check($sformatf("lock@%0d", edge_cnt), 32'(lockout_active), 32'(e.lock));
      end
    end
  end

  initial begin
    int s;
    int r0;
    int r1;
    int r2;
    int l0;
    logic [W-1:0] sw;
    logic [W-1:0] cur;
    logic [W-1:0] clr;
    int hold[W];

    rst = 1'b1;
    SWITCHES = '0;
    pend_clr = '0;
    repeat (2) cyc('0, '0, 1'b1);
    repeat (3) cyc('0, '0, 1'b0);
    check("reset_level", 32'(sw_level), 0);
    check("reset_pend", 32'(sw_pend), 0);

    // Clean press on bit 0
    r0 = rise_cnt[0];
    cyc(4'b0001, '0, 1'b0);
    s = edge_cnt + 1;
    repeat (10) cyc(4'b0001, '0, 1'b0);
    check("press_rise_edge", 32'(rise_edge[0]), 32'(s + 6));
    check("press_rise_count", 32'(rise_cnt[0] - r0), 1);

    // Bounce on bit 2, two-cycle toggles are shorter than the debounce window
    r2 = rise_cnt[2];
    for (int k = 0; k < 4; k++) begin
      sw = (k % 2 == 0) ? 4'b0101 : 4'b0001;
      repeat (2) cyc(sw, '0, 1'b0);
    end
    cyc(4'b0101, '0, 1'b0);
    s = edge_cnt + 1;
    repeat (11) cyc(4'b0101, '0, 1'b0);
    check("bounce_rise_count", 32'(rise_cnt[2] - r2), 1);
    check("bounce_rise_edge", 32'(rise_edge[2]), 32'(s + 6));

    // Clear on the same edge the rise sets the pending flag
    for (int k = 0; k < 10; k++) cyc(4'b0111, (k == 7) ? 4'b0010 : 4'b0000, 1'b0);
    check("collide_pend1", 32'(sw_pend[1]), 1);
    cyc(4'b0111, 4'b0010, 1'b0);
    cyc(4'b0111, '0, 1'b0);
    check("clear_pend1", 32'(sw_pend[1]), 0);

    // Asynchronous reset while bit 3 is mid-count
    for (int k = 0; k < 4; k++) cyc(4'b1111, '0, 1'b0);
    check("pre_reset_pend", 32'(sw_pend), 32'(4'b0101));
    async_reset(4'b1000);
    cyc(4'b1000, '0, 1'b1);
    cyc(4'b1000, '0, 1'b0);
    s = edge_cnt + 1;
    repeat (10) cyc(4'b1000, '0, 1'b0);
    check("post_reset_rise_edge", 32'(rise_edge[3]), 32'(s + 6));

    // Lockout: bit 1 rise lands inside the window, bit 2 rise after it expires
    repeat (2) cyc('0, '0, 1'b1);
    repeat (2) cyc('0, '0, 1'b0);
    r1 = rise_cnt[1];
    r2 = rise_cnt[2];
    l0 = lock_hi;
    for (int k = 0; k < 25; k++) begin
      sw = 4'b0001;
      if (k >= 3) sw[1] = 1'b1;
      if (k >= 12) sw[2] = 1'b1;
      cyc(sw, '0, 1'b0);
      if (k == 16) begin
        check("lockout_cycles", 32'(lock_hi - l0), LOCK_ON ? 32'd8 : 32'd0);
        check("lockout_bit1_rises", 32'(rise_cnt[1] - r1), LOCK_ON ? 32'd0 : 32'd1);
        check("lockout_bit1_level", 32'(sw_level[1]), 1);
      end
    end
    check("lockout_bit2_rises", 32'(rise_cnt[2] - r2), 1);
    check("lockout_levels", 32'(sw_level), 32'(4'b0111));

    // Randomized switch activity with random clears and occasional resets
    cur = '0;
    for (int i = 0; i < W; i++) hold[i] = 0;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < W; i++) begin
        if (hold[i] == 0) begin
          cur[i]  = 1'($urandom_range(0, 1));
          hold[i] = int'($urandom_range(1, 2 * D + 2));
        end else begin
          hold[i]--;
        end
      end
      clr = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
      cyc(cur, clr, ($urandom_range(0, 299) == 0));
    end

    repeat (3) cyc(cur, '0, 1'b0);
    @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
